// File: rtl/rgb_pwm_pkg.sv
// Shared constants, duty type and slew helper for the RGB PWM driver.
// Latency: n/a (package only).
// Backpressure: n/a.
package rgb_pwm_pkg;

    localparam int DUTY_W       = 8;
    localparam int PWM_CNT_MAX  = 255;
    localparam int PRESCALE_DEF = 195;   // ~1 kHz PWM from a 50 MHz clock
    localparam int STEP_DEF     = 4;

    typedef logic [DUTY_W-1:0] duty_t;

    // Move act toward tgt by at most step; step 0 means jump straight to tgt.
    // Steps only when the gap exceeds step, so it never overshoots or wraps.
    function automatic duty_t slew_next(duty_t act, duty_t tgt, duty_t step);
        duty_t diff;
        if (tgt >= act) begin
            diff = tgt - act;
        end else begin
            diff = act - tgt;
        end
        if ((step == '0) || (diff <= step)) begin
            return tgt;
        end else if (tgt > act) begin
            return act + step;
        end else begin
            return act - step;
        end
    endfunction

endpackage

// File: rtl/pwm_slew_channel.sv
// One colour channel: target register, slewed active duty, PWM compare output.
// Latency: target 1 clk; active duty updates only at period boundary; pwm 1 clk after counter.
// Backpressure: none; PWM_ACTIVE_LOW_EN inverts pwm_o (idle/reset level becomes 1).
module pwm_slew_channel
    import rgb_pwm_pkg::*;
#(
    parameter int STEP = STEP_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DUTY_W-1:0] tgt_i,
    input  logic              enable_i,
    input  logic              boundary_i,
    input  logic [DUTY_W-1:0] pwm_cnt_i,
    output logic              pwm_o,
    output logic              match_o
);

    // Steps larger than the duty range behave like an immediate jump.
    localparam duty_t STEP_D = (STEP > PWM_CNT_MAX) ? duty_t'(PWM_CNT_MAX) : duty_t'(STEP);

`ifdef PWM_ACTIVE_LOW_EN
    localparam logic PWM_IDLE = 1'b1;
`else
    localparam logic PWM_IDLE = 1'b0;
`endif

    duty_t tgt_q;
    duty_t act_q, act_d;
    logic  pwm_q, pwm_d;

    // Next active duty (boundary only) and next pin level.
    always_comb begin
        act_d = act_q;
        if (boundary_i) begin
            act_d = slew_next(act_q, tgt_q, STEP_D);
        end
        pwm_d = PWM_IDLE ^ (enable_i && (pwm_cnt_i < act_q));
    end

    // Channel state; reset drives the pin to its idle level without a clock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tgt_q <= '0;
            act_q <= '0;
            pwm_q <= PWM_IDLE;
        end else begin
            tgt_q <= tgt_i;
            act_q <= act_d;
            pwm_q <= pwm_d;
        end
    end

    assign pwm_o   = pwm_q;
    assign match_o = (act_q == tgt_q);

endmodule

// File: rtl/rgb_pwm_driver.sv
// RGB LED PWM driver: shared prescaler/period counter, three slewed duty channels.
// Latency: inputs sampled 1 clk, applied at next period boundary; pins registered.
// Backpressure: none; enable=0 parks counters and forces pins idle. Macro: PWM_ACTIVE_LOW_EN.
module rgb_pwm_driver
    import rgb_pwm_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEF,
    parameter int STEP     = STEP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DUTY_W-1:0] R_time_in,
    input  logic [DUTY_W-1:0] G_time_in,
    input  logic [DUTY_W-1:0] B_time_in,
    input  logic              enable,
    output logic              pwm_r,
    output logic              pwm_g,
    output logic              pwm_b,
    output logic              period_start,
    output logic              settled
);

    // PRESCALE of 1 still needs a one-bit counter that simply stays at 0.
    localparam int                PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    duty_t            pwm_cnt_q, pwm_cnt_d;
    logic             tick;
    logic             boundary;
    logic [2:0]       match;

    assign tick     = enable && (pre_cnt_q == PRE_LAST);
    assign boundary = tick && (pwm_cnt_q == duty_t'(PWM_CNT_MAX));

    // Prescaler and period counter; both held at 0 while disabled.
    always_comb begin
        pre_cnt_d = pre_cnt_q;
        pwm_cnt_d = pwm_cnt_q;
        if (!enable) begin
            pre_cnt_d = '0;
            pwm_cnt_d = '0;
        end else if (tick) begin
            pre_cnt_d = '0;
            pwm_cnt_d = pwm_cnt_q + duty_t'(1);
        end else begin
            pre_cnt_d = pre_cnt_q + PRE_W'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt_q <= '0;
            pwm_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    pwm_slew_channel #(.STEP(STEP)) u_ch_r (
        .clk_i      (clk),
        .rst_ni     (rst),
        .tgt_i      (R_time_in),
        .enable_i   (enable),
        .boundary_i (boundary),
        .pwm_cnt_i  (pwm_cnt_q),
        .pwm_o      (pwm_r),
        .match_o    (match[0])
    );

    pwm_slew_channel #(.STEP(STEP)) u_ch_g (
        .clk_i      (clk),
        .rst_ni     (rst),
        .tgt_i      (G_time_in),
        .enable_i   (enable),
        .boundary_i (boundary),
        .pwm_cnt_i  (pwm_cnt_q),
        .pwm_o      (pwm_g),
        .match_o    (match[1])
    );

    pwm_slew_channel #(.STEP(STEP)) u_ch_b (
        .clk_i      (clk),
        .rst_ni     (rst),
        .tgt_i      (B_time_in),
        .enable_i   (enable),
        .boundary_i (boundary),
        .pwm_cnt_i  (pwm_cnt_q),
        .pwm_o      (pwm_b),
        .match_o    (match[2])
    );

    // Decoded from registers so it is high in the very first enabled cycle.
    assign period_start = enable && (pwm_cnt_q == '0) && (pre_cnt_q == '0);
    assign settled      = &match;

endmodule

// File: doc/rgb_pwm_driver.md
Name: rgb_pwm_driver

Overview:
Downstream stage of the colour-sequencer FSM. Consumes the three 8-bit duty words (R/G/B time values) and drives the three RGB LED pins with fixed-frequency PWM. Duty changes are applied only at PWM period boundaries (glitch-free), with optional per-period slew so colour transitions fade instead of jumping.

Parameters:
PRESCALE, 195, clk cycles per PWM count tick (≈1 kHz PWM at 50 MHz); legal range ≥1
STEP, 4, max change of an active duty per PWM period; 0 = apply target immediately

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
R_time_in  in  8  red target duty, 0..255
G_time_in  in  8  green target duty
B_time_in  in  8  blue target duty
enable  in  1  1 = run PWM; 0 = outputs off, counters parked
pwm_r  out  1  red LED drive
pwm_g  out  1  green LED drive
pwm_b  out  1  blue LED drive
period_start  out  1  one-cycle pulse at the first cycle of each PWM period
settled  out  1  1 when all three active duties equal their targets

Behaviour:
- Reset (rst=0, async): pre_cnt=0, pwm_cnt=0, targets=0, active duties=0, pwm_r/g/b=0, settled=1. Outputs go low immediately, no clock edge needed.
- Targets: R/G/B_time_in registered every clk into tgt_x (1-cycle latency).
- Prescaler pre_cnt counts 0..PRESCALE-1 and wraps; tick = (pre_cnt==PRESCALE-1).
- pwm_cnt (8 bit) increments on tick and wraps 255→0. Period = 256*PRESCALE clk.
- Boundary = tick && pwm_cnt==255. At boundary, per channel: if STEP==0 or |tgt-act|≤STEP then act←tgt; else act←act±STEP toward tgt. Never overshoots; no wrap.
- act_x changes only at boundaries; mid-period input changes never alter the current period's waveform.
- pwm_x registered: pwm_x ← enable && (pwm_cnt < act_x). Duty 0 = constantly low; 255 = high 255/256 of period (100% is not reachable by design).
- period_start = enable && pwm_cnt==0 && pre_cnt==0 (decoded from registers, 1 clk wide).
- settled = (act_r==tgt_r)&&(act_g==tgt_g)&&(act_b==tgt_b), combinational from registers.
- enable=0: pre_cnt and pwm_cnt held at 0, act_x frozen (no slewing), pwm_x forced 0 on the next edge. On re-enable, counting resumes from 0; period_start is asserted in the first enabled cycle.
- Target change in the same cycle as a boundary: the boundary uses the tgt_x value registered on the previous edge.

Optional Feature:
PWM_ACTIVE_LOW_EN: when defined, pwm_r/g/b are inverted for common-anode LEDs (reset value 1; enable=0 drives 1). When not defined, outputs are active-high as above. period_start and settled are unaffected either way.

Decomposition:
- Package rgb_pwm_pkg: DUTY_W=8, PWM_CNT_MAX=255, default PRESCALE and STEP constants, duty_t typedef (8-bit).
- Sub-module pwm_slew_channel, instantiated 3×: tgt register, act register with slew step, compare/output register, per-channel match flag. The top holds the shared prescaler, pwm_cnt, period_start and settled AND.

Test Plan (PRESCALE=2, so period = 512 clk):
1. Hold rst=0 with inputs 255 and enable=1 → all pwm 0, settled=1. Release with STEP=0 → act=255 at first boundary; settled goes 0 then 1.
2. STEP=0, R=64, G=0, B=255 → per period, pwm_r high 128 clk, pwm_g never high, pwm_b high 510 clk. period_start pulses every 512 clk.
3. STEP=4, act_r=0, R=10 → act_r 4, 8, 10 on three successive boundaries, settled low until the third. Then R=0 → 6, 2, 0.
4. R changed 64→200 mid-period → current period keeps the 128-clk high time; the next period is 400 clk high.
5. enable→0 mid-period → pwm all 0 next cycle, counters 0. enable→1 → period_start in the first enabled cycle; duties unchanged.
6. Async rst pulse mid-period with act=200 → outputs 0 without a clock edge; after release act=0 and settled=1.
